ms_timer_scheduler: RTL
=======================

Name: ms_timer_scheduler

Overview:
Shares one 1 kHz timebase among four requesters that each need a millisecond delay timer. Contains a free-running prescaler that generates a 1-cycle tick. A round-robin arbiter grants at most one timer load per clock. Four independent down-counters signal expiry with a 1-cycle done pulse. Sits between the board clock and lab control FSMs (debounce, display scan, stopwatch) that need ms-resolution delays.

Parameters:
CLK_DIV, 100000, clk_i cycles per tick (100 MHz -> 1 kHz); minimum 2; benches use 10.
DLY_W, 16, width of each channel's delay and remaining count.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  asynchronous, active-low reset.
pause_i  in  1  freezes prescaler and suppresses ticks while high.
req_i  in  4  per-channel load request, level; held until own gnt_o bit seen.
dly_i  in  4*DLY_W  packed delays; channel k uses bits [k*DLY_W +: DLY_W]; sampled on grant.
cancel_i  in  4  per-channel abort, sampled each cycle.
tick_o  out  1  1-cycle pulse every CLK_DIV cycles.
gnt_o  out  4  one-hot/zero, registered, 1-cycle load acknowledge.
busy_o  out  4  channel armed.
done_o  out  4  1-cycle expiry pulse per channel.

Behaviour:
- Reset (async, rst_i=0): prescaler=0, tick_o=0, gnt_o=0, busy_o=0, done_o=0, all remaining counts=0, RR pointer=0. Reset mid-count discards all timers; no done pulses.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick_o is registered and high for exactly the cycle after count reaches CLK_DIV-1.
- pause_i=1: count holds and no ticks. Grants, cancels and D=0 completions continue.
- Channel states: IDLE (busy=0) and ARMED (busy=1). Remaining count rem[k] is DLY_W bits.
- Eligibility: req_i[k] & ~busy[k] & ~cancel_i[k].
- Arbitration: search eligible channels starting at pointer p, ascending mod 4; first hit wins. At the clock edge:
  - gnt_o = one-hot of the winner.
  - rem[k] = dly_i slice.
  - busy[k] = 1.
  - p = winner+1 mod 4.
  - No eligible channel: gnt_o=0 and p unchanged.
- Request hold: requester drops req_i the cycle after gnt_o. A still-high req_i in that cycle is ignored because busy=1.
- Countdown, ARMED channel, D>=1: on each tick_o cycle rem decrements. When rem==1 and tick_o, at that edge rem=0, busy=0 and done_o[k]=1 for one cycle.
  - Expiry time after grant is in ((D-1)*CLK_DIV, D*CLK_DIV] cycles.
- D=0: the channel is ARMED for exactly one cycle. At the next edge busy=0 and done_o[k]=1, independent of tick and pause.
- cancel_i[k] while ARMED: at the edge busy=0, rem=0, no done pulse.
  - Cancel beats an expiry in the same cycle.
  - Cancel on an IDLE channel is ignored.
- Channels are independent. Several done_o bits may pulse in the same cycle.
- A channel may be re-granted in the cycle after its done pulse.

Test Plan:
1. CLK_DIV=10, no requests: tick_o pulses at cycles 10, 20, 30 after reset release, 1 cycle wide. pause_i high for 25 cycles -> no ticks in that window; phase resumes from the held count.
2. req_i=0001, D=3, granted at edge t -> gnt_o=0001 at t, busy_o[0]=1 for 3 ticks. done_o[0] pulses once on the cycle after the 3rd tick; busy_o[0] falls at that edge.
3. req_i=1111 held, each channel dropping on its grant, D=5 each -> gnt_o sequence 0001, 0010, 0100, 1000 on consecutive cycles. Then at p=0, reqs 1010 -> 0010 then 1000.
4. Channel 2 armed with D=4; cancel_i[2] asserted in the same cycle as the 4th tick -> busy_o[2]=0 and done_o[2] never pulses.
5. D=0 on channel 1 -> gnt_o=0010, busy_o[1]=1 for exactly one cycle, done_o[1] next cycle. Repeat with pause_i=1 -> same result.
6. Channels 0 and 3 armed at different times with identical expiry ticks -> done_o=1001 in one cycle. rst_i pulsed low mid-count -> all outputs 0 immediately; no done pulses after release.

Source files
------------

// File: rtl/ms_timer_scheduler.sv
// Four millisecond delay timers sharing one prescaled tick; a round-robin
// arbiter accepts at most one timer load per clock.
module ms_timer_chan #(
    parameter int DLY_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [DLY_W-1:0] dly_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o
);
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DLY_W-1:0] rem_q, rem_d;

    // rem==0 while armed only happens for a zero-length load: expire at once.
    always_comb begin
        busy_d = busy_q;
        rem_d  = rem_q;
        done_d = 1'b0;
        if (busy_q) begin
            if (cancel_i) begin
                busy_d = 1'b0;
                rem_d  = '0;
            end else if (rem_q == '0 || (tick_i && rem_q == DLY_W'(1))) begin
                busy_d = 1'b0;
                rem_d  = '0;
                done_d = 1'b1;
            end else if (tick_i) begin
                rem_d = rem_q - DLY_W'(1);
            end
        end else if (load_i) begin
            busy_d = 1'b1;
            rem_d  = dly_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            rem_q  <= rem_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

module ms_timer_scheduler #(
    parameter int CLK_DIV = 100000,
    parameter int DLY_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pause_i,
    input  logic [3:0]         req_i,
    input  logic [4*DLY_W-1:0] dly_i,
    input  logic [3:0]         cancel_i,
    output logic               tick_o,
    output logic [3:0]         gnt_o,
    output logic [3:0]         busy_o,
    output logic [3:0]         done_o
);
    localparam int NCH = 4;
    localparam int CW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    elig;
    logic [1:0]    idx;
    logic          found;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!pause_i) begin
            tick_d = (cnt_q == CW'(CLK_DIV - 1));
            cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
        end
    end

    assign elig = req_i & ~busy_o & ~cancel_i;

    // First eligible channel at or after the pointer wins.
    always_comb begin
        gnt_d = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && elig[idx]) begin
                found      = 1'b1;
                gnt_d[idx] = 1'b1;
                ptr_d      = idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            gnt_q  <= '0;
            ptr_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            gnt_q  <= gnt_d;
            ptr_q  <= ptr_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ms_timer_chan #(.DLY_W(DLY_W)) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .tick_i   (tick_q),
            .load_i   (gnt_d[k]),
            .dly_i    (dly_i[k*DLY_W +: DLY_W]),
            .cancel_i (cancel_i[k]),
            .busy_o   (busy_o[k]),
            .done_o   (done_o[k])
        );
    end

    assign tick_o = tick_q;
    assign gnt_o  = gnt_q;
endmodule
